// File: rtl/parkimetro_credito.sv
// parkimetro_credito -- per-space parking credit controller.
// Tracks paid minutes (credito) while a car is parked, counts overtime
// minutes (exceso) once the credit runs out, rejects coins that cannot be
// used, and drops into a fault state while the sensor stage reports error.
// Optional feature: define PARKIMETRO_AVISO_EN to drive the low-credit
// warning output aviso; without it aviso is tied low.
module parkimetro_credito #(
  parameter int MINUTOS_MONEDA = 15,
  parameter int CREDITO_MAX    = 240,
  parameter int GRACIA         = 2,
  parameter int AVISO_UMBRAL   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entra,
  input  logic       sale,
  input  logic       error,
  input  logic       moneda,
  input  logic       tick,
  output logic [7:0] credito,
  output logic [7:0] exceso,
  output logic [1:0] estado,
  output logic       vencido,
  output logic       alarma,
  output logic       devolver,
  output logic       aviso
);

  typedef enum logic [1:0] {
    LIBRE   = 2'b00,
    OCUPADO = 2'b01,
    VENCIDO = 2'b10,
    FALLA   = 2'b11
  } estado_t;

  localparam logic [8:0] MONEDA_W = 9'(MINUTOS_MONEDA);
  localparam logic [8:0] MAX_W    = 9'(CREDITO_MAX);
  localparam logic [7:0] GRACIA_W = 8'(GRACIA);

  // Elaboration-time sanity checks on the configuration.
  if (CREDITO_MAX > 255) begin : g_chk_max
    $error("CREDITO_MAX must fit in 8 bits");
  end
  if (GRACIA > CREDITO_MAX) begin : g_chk_gracia
    $error("GRACIA must not exceed CREDITO_MAX");
  end
  if (AVISO_UMBRAL > 255) begin : g_chk_umbral
    $error("AVISO_UMBRAL must fit in 8 bits");
  end

  estado_t    estado_q, estado_d;
  logic [7:0] credito_q, credito_d;
  logic [7:0] exceso_q, exceso_d;
  logic       devolver_q, devolver_d;

  // Credit after an optional same-cycle tick, and that value plus one coin.
  // Both are 9 bits wide so the ceiling comparison cannot wrap.
  logic [8:0] tras_tick_w;
  logic [8:0] con_moneda_w;

  assign tras_tick_w  = {1'b0, credito_q} - {8'd0, tick};
  assign con_moneda_w = tras_tick_w + MONEDA_W;

  // Next-state and next-output computation, prioritised error > sale > entra > moneda/tick.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    estado_d   = estado_q;
    credito_d  = credito_q;
    exceso_d   = exceso_q;
    devolver_d = 1'b0;

    if (error) begin
      estado_d   = FALLA;
      credito_d  = 8'd0;
      exceso_d   = 8'd0;
      devolver_d = moneda;
    end else begin
      unique case (estado_q)
        LIBRE: begin
          // No car to credit: any coin goes straight back.
          devolver_d = moneda;
          if (entra) begin
            credito_d = GRACIA_W;
            exceso_d  = 8'd0;
            estado_d  = (GRACIA == 0) ? VENCIDO : OCUPADO;
          end
        end

        FALLA: begin
          devolver_d = moneda;
          estado_d   = LIBRE;
        end

        OCUPADO: begin
          if (sale) begin
            estado_d  = LIBRE;
            credito_d = 8'd0;
            exceso_d  = 8'd0;
          end else begin
            credito_d = tras_tick_w[7:0];
            if (moneda) begin
              if (con_moneda_w <= MAX_W) begin
                credito_d = con_moneda_w[7:0];
              end else begin
                devolver_d = 1'b1;
              end
            end
            if (credito_d == 8'd0) begin
              estado_d = VENCIDO;
            end
          end
        end

        VENCIDO: begin
          if (sale) begin
            estado_d  = LIBRE;
            credito_d = 8'd0;
            exceso_d  = 8'd0;
          end else if (moneda) begin
            // A fresh coin restarts paid time; overtime already owed is kept.
            credito_d = MONEDA_W[7:0];
            estado_d  = (MINUTOS_MONEDA == 0) ? VENCIDO : OCUPADO;
          end else if (tick && (exceso_q != 8'hFF)) begin
            exceso_d = exceso_q + 8'd1;
          end
        end

        default: estado_d = LIBRE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      estado_q   <= LIBRE;
      credito_q  <= 8'd0;
      exceso_q   <= 8'd0;
      devolver_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      credito_q  <= credito_d;
      exceso_q   <= exceso_d;
      devolver_q <= devolver_d;
    end
  end

`ifdef PARKIMETRO_AVISO_EN
  logic aviso_q, aviso_d;

  assign aviso_d = (estado_d == OCUPADO) && ({1'b0, credito_d} <= 9'(AVISO_UMBRAL));

  // Low-credit warning, registered alongside the credit it describes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      aviso_q <= 1'b0;
    end else begin
      aviso_q <= aviso_d;
    end
  end

  assign aviso = aviso_q;
`else
  assign aviso = 1'b0;
`endif

  assign estado   = estado_q;
  assign credito  = credito_q;
  assign exceso   = exceso_q;
  assign devolver = devolver_q;
  assign vencido  = (estado_q == VENCIDO);
  assign alarma   = (estado_q == FALLA);

endmodule

// File: tb/tb_parkimetro_credito.sv
// Self-checking bench for parkimetro_credito: a cycle model pushes the
// expected outputs into a scoreboard queue as stimulus is applied, and each
// entry is popped and compared one time unit after the clock edge.
// Directed scenarios are followed by constant spot checks and a random run.
module tb_parkimetro_credito;

  localparam int MIN_M  = 15;
  localparam int MAX_C  = 240;
  localparam int GRAC   = 2;
  localparam int UMBRAL = 5;
`ifdef PARKIMETRO_AVISO_EN
  localparam bit AV_EN = 1'b1;
`else
  localparam bit AV_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, entra, sale, error, moneda, tick;
  logic [7:0] credito, exceso;
  logic [1:0] estado;
  logic       vencido, alarma, devolver, aviso;

  parkimetro_credito #(
    .MINUTOS_MONEDA(MIN_M),
    .CREDITO_MAX   (MAX_C),
    .GRACIA        (GRAC),
    .AVISO_UMBRAL  (UMBRAL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .entra   (entra),
    .sale    (sale),
    .error   (error),
    .moneda  (moneda),
    .tick    (tick),
    .credito (credito),
    .exceso  (exceso),
    .estado  (estado),
    .vencido (vencido),
    .alarma  (alarma),
    .devolver(devolver),
    .aviso   (aviso)
  );

  always #5 clk = ~clk;

  typedef struct {
    int est;
    int cred;
    int exc;
    int dev;
    int av;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_est = 0, m_cred = 0, m_exc = 0;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Behavioural model: returns the outputs expected after the coming edge.
  function automatic exp_t model(input bit r, input bit er, input bit s, input bit en,
                                 input bit m, input bit t);
    exp_t e;
    int   c;
    int   dev = 0;
    if (!r) begin
      m_est = 0; m_cred = 0; m_exc = 0;
    end else if (er) begin
      m_est = 3; m_cred = 0; m_exc = 0; dev = m;
    end else if (m_est == 0) begin
      dev = m;
      if (en) begin
        m_cred = GRAC; m_exc = 0; m_est = (GRAC == 0) ? 2 : 1;
      end
    end else if (m_est == 3) begin
      dev = m; m_est = 0;
    end else if (s) begin
      m_est = 0; m_cred = 0; m_exc = 0;
    end else if (m_est == 1) begin
      c = m_cred - (t ? 1 : 0);
      if (m) begin
        if (c + MIN_M <= MAX_C) c = c + MIN_M;
        else dev = 1;
      end
      m_cred = c;
      if (c == 0) m_est = 2;
    end else begin
      if (m) begin
        m_cred = MIN_M; m_est = 1;
      end else if (t && m_exc < 255) begin
        m_exc = m_exc + 1;
      end
    end
    e.est  = m_est;
    e.cred = m_cred;
    e.exc  = m_exc;
    e.dev  = dev;
    e.av   = (AV_EN && m_est == 1 && m_cred <= UMBRAL) ? 1 : 0;
    return e;
  endfunction

  // One clock cycle: drive inputs, push expectation, compare after the edge.
  task automatic step(input string tag, input bit r, input bit er, input bit s,
                      input bit en, input bit m, input bit t);
    exp_t e;
    @(negedge clk);
    reset = r; error = er; sale = s; entra = en; moneda = m; tick = t;
    exp_q.push_back(model(r, er, s, en, m, t));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_estado"}, int'(estado), e.est);
      check({tag, "_credito"}, int'(credito), e.cred);
      check({tag, "_exceso"}, int'(exceso), e.exc);
      check({tag, "_devolver"}, int'(devolver), e.dev);
      check({tag, "_vencido"}, int'(vencido), (e.est == 2) ? 1 : 0);
      check({tag, "_alarma"}, int'(alarma), (e.est == 3) ? 1 : 0);
      check({tag, "_aviso"}, int'(aviso), e.av);
    end
  endtask

  // Shorthand for a normal-operation cycle (reset released, no error).
  task automatic op(input string tag, input bit s, input bit en, input bit m, input bit t);
    step(tag, 1'b1, 1'b0, s, en, m, t);
  endtask

  int dev_count;

  initial begin
    reset = 1'b0; entra = 1'b0; sale = 1'b0; error = 1'b0; moneda = 1'b0; tick = 1'b0;

    // Reset, with other inputs active to show reset overrides them.
    step("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("rst_estado", int'(estado), 0);
    check("rst_devolver", int'(devolver), 0);

    // Coin in LIBRE is returned for a single cycle.
    op("libre_coin", 0, 0, 1, 0);
    check("libre_dev_hi", int'(devolver), 1);
    check("libre_cred", int'(credito), 0);
    op("libre_idle", 0, 0, 0, 0);
    check("libre_dev_lo", int'(devolver), 0);

    // Arrival and expiry.
    op("arr_entra", 0, 1, 0, 0);
    check("arr_cred2", int'(credito), 2);
    check("arr_est1", int'(estado), 1);
    op("arr_t1", 0, 0, 0, 1);
    check("arr_cred1", int'(credito), 1);
    op("arr_t2", 0, 0, 0, 1);
    check("arr_cred0", int'(credito), 0);
    check("arr_est2", int'(estado), 2);
    check("arr_venc", int'(vencido), 1);
    for (int i = 0; i < 3; i++) op("exc_tick", 0, 0, 0, 1);
    check("exc3", int'(exceso), 3);

    // Overtime then payment, then leaving with a same-cycle tick.
    for (int i = 0; i < 4; i++) op("exc_tick", 0, 0, 0, 1);
    check("exc7", int'(exceso), 7);
    op("venc_coin", 0, 0, 1, 0);
    check("venc_coin_cred", int'(credito), 15);
    check("venc_coin_exc", int'(exceso), 7);
    check("venc_coin_est", int'(estado), 1);
    op("sale_tick", 1, 0, 0, 1);
    check("sale_est", int'(estado), 0);
    check("sale_cred", int'(credito), 0);
    check("sale_exc", int'(exceso), 0);

    // Payment up to the ceiling: 15 accepted coins, 16th returned.
    op("pay_entra", 0, 1, 0, 0);
    dev_count = 0;
    for (int i = 0; i < 16; i++) begin
      op("pay_coin", 0, 0, 1, 0);
      dev_count += int'(devolver);
    end
    check("pay_cred227", int'(credito), 227);
    check("pay_dev_once", dev_count, 1);
    op("pay_sale", 1, 0, 0, 0);

    // Coin and tick in the same cycle at credito=1, then the warning threshold.
    op("ct_entra", 0, 1, 0, 0);
    op("ct_t", 0, 0, 0, 1);
    op("ct_both", 0, 0, 1, 1);
    check("ct_cred15", int'(credito), 15);
    check("ct_est1", int'(estado), 1);
    for (int i = 0; i < 5; i++) op("av_tick", 0, 0, 0, 1);
    check("av_cred10", int'(credito), 10);
    check("av_off", int'(aviso), 0);
    for (int i = 0; i < 5; i++) op("av_tick", 0, 0, 0, 1);
    check("av_cred5", int'(credito), 5);
    check("av_on", int'(aviso), AV_EN ? 1 : 0);

    // Fault: reach credito=30, then error with entra for 4 cycles.
    op("f_coin", 0, 0, 1, 0);
    op("f_coin", 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) op("f_tick", 0, 0, 0, 1);
    check("f_cred30", int'(credito), 30);
    for (int i = 0; i < 4; i++) step("f_err", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("f_est3", int'(estado), 3);
    check("f_alarma", int'(alarma), 1);
    check("f_cred0", int'(credito), 0);
    op("f_clear", 0, 0, 0, 0);
    check("f_libre", int'(estado), 0);

    // Reset in the middle of OCUPADO.
    op("r_entra", 0, 1, 0, 0);
    op("r_coin", 0, 0, 1, 0);
    step("r_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("r_est", int'(estado), 0);
    check("r_cred", int'(credito), 0);
    check("r_dev", int'(devolver), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
